instr_encoder_loader: RTL
=========================

Name: instr_encoder_loader

Overview:
- Inverse of the main control decoder: accepts symbolic operations (R-format, ld, sd, beq) over a valid/ready handshake.
- Encodes each one into a 32-bit RV64 instruction word.
- Writes the words sequentially into instruction memory through a write/ack handshake.
- Used by the test and boot infrastructure to load programs into the CPU's instruction memory.

Parameters:
- ADDR_WIDTH, 10, byte-address width of imem_addr.
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.
- DEPTH_WORDS, 256, maximum number of words loaded before the block reports full.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  operation request valid.
- op_ready  out  1  block can accept a request this cycle.
- op_kind  in  2  operation kind: 00=R, 01=ld, 10=sd, 11=beq.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R only.
- rd  in  5  destination register; used by R and ld.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2; used by R, sd and beq.
- imm  in  13  signed immediate; ld/sd use imm[11:0], beq uses imm[12:1].
- imem_we  out  1  write request to instruction memory.
- imem_addr  out  ADDR_WIDTH  byte address of the write.
- imem_wdata  out  32  encoded instruction word.
- imem_ack  in  1  memory accepted the write this cycle.
- restart  in  1  pulse: reset the write pointer to BASE_ADDR and clear full.
- count  out  $clog2(DEPTH_WORDS+1)  words written since reset or restart.
- full  out  1  DEPTH_WORDS words have been written.
- err  out  1  sticky field-check error; driven only with the optional feature, otherwise tied to 0.

Behaviour:
- Reset values: op_ready=0 during reset and 1 in the first cycle after; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; count=0; full=0; err=0; FSM in IDLE.
- IDLE state:
  - op_ready = !full.
  - A handshake (op_valid && op_ready) registers the encoded word into imem_wdata and moves the FSM to WRITE.
- WRITE state:
  - op_ready=0; imem_we=1.
  - imem_addr and imem_wdata are held stable until imem_ack.
  - An ack in the same cycle imem_we first rises is legal: one write per WRITE cycle with ack.
- On imem_ack:
  - imem_addr += 4, wrapping modulo 2^ADDR_WIDTH.
  - count += 1.
  - If count reaches DEPTH_WORDS, full=1.
  - Return to IDLE. Minimum throughput is 1 word per 2 cycles.
- full=1: op_ready=0. Only restart or reset clears full.
- restart:
  - Honoured only in IDLE: sets imem_addr=BASE_ADDR, count=0, full=0; err is unchanged.
  - Ignored in WRITE, so an in-flight write always completes.
  - restart and op_valid in the same IDLE cycle: restart wins and the request is not accepted (op_ready forced to 0 that cycle).
- Reset mid-WRITE: imem_we drops the next cycle; the pending word is discarded.
- Encodings (MSB to LSB):
  - R: funct7 | rs2 | rs1 | funct3 | rd | 0110011
  - ld: imm[11:0] | rs1 | funct3 | rd | 0000011
  - sd: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | 0100011
  - beq: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011
- Unused fields for each kind are ignored.

Optional Feature:
- Macro: ENC_FIELD_CHECK_EN.
- When defined, a request is rejected if either condition holds:
  - beq with imm[0]=1;
  - ld/sd with imm[12]!=imm[11], i.e. not representable in 12 bits.
- A rejected request is still handshaken (consumed) but not written: err set sticky, FSM stays in IDLE, count unchanged.
- err clears only on reset.
- When not defined: imm[0] is ignored for beq, imm[12] is ignored for ld/sd, and err is tied to 0.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants OPC_RTYPE=0110011, OPC_LOAD=0000011, OPC_STORE=0100011, OPC_BRANCH=1100011;
  - the op_kind enum;
  - the FSM state enum.
- The main control decoder imports the same opcode constants.
- One sub-module, instr_encode: purely combinational op fields to 32-bit word (plus check flag), instantiated once ahead of the imem_wdata register.

Test Plan:
- R-format: kind=R, funct7=0, rs2=2, rs1=1, funct3=0, rd=3, ack on first WRITE cycle -> imem_wdata=0x002081B3 at addr 0x000; count=1; op_ready back to 1 two cycles after the handshake.
- ld/sd with slow ack: ld, imm=8, rs1=2, funct3=3, rd=5 -> 0x00813283 at 0x000; then sd, imm=16, rs2=5, rs1=2, funct3=3 with ack delayed 3 cycles -> imem_we held 4 cycles with stable 0x00513823 at 0x004.
- beq negative offset: rs1=1, rs2=2, funct3=0, imm=-8 -> 0xFE208CE3.
- Full: DEPTH_WORDS=4, five back-to-back requests -> four writes at 0x0, 0x4, 0x8, 0xC; full=1, op_ready=0, fifth request not accepted; restart in IDLE -> count=0, next write at 0x0.
- Reset mid-WRITE, plus restart during WRITE: restart asserted with ack pending -> ignored, write completes at the current addr. Reset asserted while imem_we=1 -> imem_we=0 and count=0 the next cycle.
- ENC_FIELD_CHECK_EN defined: beq with imm=3 -> no imem_we, err=1, count unchanged, next valid op written normally.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// ----------------------------------------------------------------------------
// cpu_isa_pkg
//   Shared ISA definitions for the CPU and its program loader. It holds the
//   RV64 major opcodes, the symbolic operation kinds accepted by the loader,
//   and the loader FSM state type.
//   Ports: none (package).
// ----------------------------------------------------------------------------
package cpu_isa_pkg;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      KIND_R   = 2'b00,
      KIND_LD  = 2'b01,
      KIND_SD  = 2'b10,
      KIND_BEQ = 2'b11
   } op_kind_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } enc_state_e;

endpackage

// File: rtl/instr_encode.sv
// ----------------------------------------------------------------------------
// instr_encode
//   Purely combinational encoder from symbolic operation fields to a 32-bit
//   RV64 instruction word. It also flags immediates that the target format
//   cannot represent.
//   Ports:
//     op_kind   in  2   00=R, 01=ld, 10=sd, 11=beq
//     funct3    in  3   funct3 field
//     funct7    in  7   funct7 field (R only)
//     rd        in  5   destination register (R, ld)
//     rs1       in  5   source register 1
//     rs2       in  5   source register 2 (R, sd, beq)
//     imm       in  13  signed immediate
//     word      out 32  encoded instruction
//     field_bad out 1   beq with odd offset, or ld/sd immediate wider than 12 bits
// ----------------------------------------------------------------------------
module instr_encode
   import cpu_isa_pkg::*;
(
   input  logic [1:0]  op_kind,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [12:0] imm,
   output logic [31:0] word,
   output logic        field_bad
);

   always_comb begin
      word      = '0;
      field_bad = 1'b0;
      case (op_kind_e'(op_kind))
         KIND_R: begin
            word = {funct7, rs2, rs1, funct3, rd, OPC_RTYPE};
         end
         KIND_LD: begin
            word      = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            field_bad = imm[12] != imm[11];
         end
         KIND_SD: begin
            word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            field_bad = imm[12] != imm[11];
         end
         KIND_BEQ: begin
            word      = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            field_bad = imm[0];
         end
         default: begin
            word      = '0;
            field_bad = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// ----------------------------------------------------------------------------
// instr_encoder_loader
//   Accepts symbolic operations over valid/ready, encodes each into a 32-bit
//   RV64 word and writes the words sequentially into instruction memory over
//   a write/ack handshake.
//   Optional macro ENC_FIELD_CHECK_EN: rejects unrepresentable immediates.
//   Rejected requests are consumed but not written, and they set a sticky err.
//   Ports:
//     clk, reset          clock (rising edge), synchronous active-high reset
//     op_valid/op_ready   request handshake
//     op_kind..imm        operation fields (see instr_encode)
//     imem_we/addr/wdata  instruction memory write request
//     imem_ack            memory accepted the write this cycle
//     restart             rewind write pointer to BASE_ADDR, clear count/full
//     count               words written since reset/restart
//     full                DEPTH_WORDS words written
//     err                 sticky field-check error (0 without the macro)
// ----------------------------------------------------------------------------
module instr_encoder_loader
   import cpu_isa_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned BASE_ADDR   = 0,
   parameter int unsigned DEPTH_WORDS = 256
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               op_valid,
   output logic                               op_ready,
   input  logic [1:0]                         op_kind,
   input  logic [2:0]                         funct3,
   input  logic [6:0]                         funct7,
   input  logic [4:0]                         rd,
   input  logic [4:0]                         rs1,
   input  logic [4:0]                         rs2,
   input  logic [12:0]                        imm,
   output logic                               imem_we,
   output logic [ADDR_WIDTH-1:0]              imem_addr,
   output logic [31:0]                        imem_wdata,
   input  logic                               imem_ack,
   input  logic                               restart,
   output logic [$clog2(DEPTH_WORDS+1)-1:0]   count,
   output logic                               full,
   output logic                               err
);

   localparam int unsigned         CW    = $clog2(DEPTH_WORDS + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CW-1:0]       DEPTH = CW'(DEPTH_WORDS);

   enc_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q,  full_d;

   logic [31:0] enc_word;
   logic        field_bad;
   logic        accept;
   logic        reject;

   instr_encode u_encode (
      .op_kind   (op_kind),
      .funct3    (funct3),
      .funct7    (funct7),
      .rd        (rd),
      .rs1       (rs1),
      .rs2       (rs2),
      .imm       (imm),
      .word      (enc_word),
      .field_bad (field_bad)
   );

   // restart takes priority over a same-cycle request, so it masks ready.
   assign op_ready = (state_q == ST_IDLE) && !full_q && !restart && !reset;
   assign accept   = op_valid && op_ready;

`ifdef ENC_FIELD_CHECK_EN
   logic err_q, err_d;

   assign reject = field_bad;
   assign err    = err_q;

   always_comb begin
      err_d = err_q;
      if (accept && field_bad) begin
         err_d = 1'b1;
      end
   end

   // err survives restart; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   logic unused_field_bad;

   assign unused_field_bad = field_bad;
   assign reject           = 1'b0;
   assign err              = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      full_d  = full_q;
      case (state_q)
         ST_IDLE: begin
            if (restart) begin
               addr_d  = BASE;
               count_d = '0;
               full_d  = 1'b0;
            end else if (accept && !reject) begin
               wdata_d = enc_word;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (imem_ack) begin
               addr_d  = addr_q + ADDR_WIDTH'(4);
               count_d = count_q + CW'(1);
               full_d  = (count_q + CW'(1)) == DEPTH;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE;
         wdata_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
         full_q  <= full_d;
      end
   end

   assign imem_we    = (state_q == ST_WRITE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign count      = count_q;
   assign full       = full_q;

endmodule
